// File: rtl/dab_pkg.sv
// Shared types and constants for the DAB phase-shift modulator sequencer.
package dab_pkg;

  localparam int TAU_W = 9;
  localparam int FS_W  = 19;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_RUN      = 3'd2,
    ST_STOPPING = 3'd3,
    ST_FAULT    = 3'd4
  } dab_state_t;

  typedef enum logic [1:0] {
    FC_NONE = 2'd0,
    FC_TRIP = 2'd1,
    FC_WDOG = 2'd2
  } dab_fault_t;

  // Legal command ranges; the upper t1/t2/phi limits are implied by the 9-bit signed width.
  localparam logic signed [FS_W-1:0]  FS_MIN     = 19'sd1000;
  localparam logic signed [FS_W-1:0]  FS_MAX     = 19'sd150000;
  localparam logic signed [FS_W-1:0]  FS_DEFAULT = 19'sd50000;
  localparam logic signed [TAU_W-1:0] TAU_MIN    = 9'sd0;
  localparam logic signed [TAU_W-1:0] PHI_MIN    = -9'sd255;

  localparam logic [7:0] TAU_STEP = 8'd8;
  localparam logic [7:0] PHI_STEP = 8'd4;

  localparam int unsigned SYNC_LEN         = 4;
  localparam int unsigned WDOG_CYC_DEFAULT = 100000;

  function automatic logic cmd_legal(
    input logic signed [TAU_W-1:0] t1,
    input logic signed [TAU_W-1:0] t2,
    input logic signed [TAU_W-1:0] phi,
    input logic signed [FS_W-1:0]  fs
  );
    return (t1 >= TAU_MIN) && (t2 >= TAU_MIN) && (phi >= PHI_MIN) &&
           (fs >= FS_MIN) && (fs <= FS_MAX);
  endfunction

endpackage

// File: rtl/dab_ramp_step.sv
// One-channel slew limiter: moves cur toward tgt by at most step when en is high,
// landing exactly on tgt without overshoot. Differences are taken in 10 bits so
// the full -255..255 span cannot wrap.
module dab_ramp_step
  import dab_pkg::*;
(
  input  logic signed [TAU_W-1:0] cur,
  input  logic signed [TAU_W-1:0] tgt,
  input  logic        [7:0]       step,
  input  logic                    en,
  output logic signed [TAU_W-1:0] next
);

  logic signed [TAU_W:0] diff;
  logic signed [TAU_W:0] lim;
  logic signed [TAU_W:0] delta;

  // Clamp the remaining distance to +/-step and apply it.
  always_comb begin
    diff  = $signed({tgt[TAU_W-1], tgt}) - $signed({cur[TAU_W-1], cur});
    lim   = $signed({2'b00, step});
    delta = diff;
    if (diff > lim)
      delta = lim;
    else if (diff < -lim)
      delta = -lim;
    next = en ? TAU_W'($signed({cur[TAU_W-1], cur}) + delta) : cur;
  end

endmodule

// File: rtl/dab_mod_sequencer.sv
// Sequencer/configurator for the DAB phase-shift modulator: command intake with
// range check, period-aligned parameter updates with slew limiting, start sync,
// soft stop, trip shutdown and period watchdog.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  IDLE     | converter off, outputs 0, shadow copied to targets at once
//  START    | sync pulse to modulator for SYNC_LEN cycles
//  RUN      | ramp toward targets each period_start, shadow applied there
//  STOPPING | ramp t1/t2 down to 0 with phi held, then back to IDLE
//  FAULT    | outputs forced to 0 until fault_clr with trip released
module dab_mod_sequencer
  import dab_pkg::*;
#(
  parameter int unsigned WDOG_CYC = WDOG_CYC_DEFAULT
)
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic signed [TAU_W-1:0] cmd_t1,
  input  logic signed [TAU_W-1:0] cmd_t2,
  input  logic signed [TAU_W-1:0] cmd_phi,
  input  logic signed [FS_W-1:0]  cmd_fs,
  output logic                    cmd_err,
  input  logic                    enable,
  input  logic                    trip,
  input  logic                    fault_clr,
  input  logic                    period_start,
  output logic signed [TAU_W-1:0] t1,
  output logic signed [TAU_W-1:0] t2,
  output logic signed [TAU_W-1:0] phi,
  output logic signed [FS_W-1:0]  fs_DAB,
  output logic                    sync,
  output logic                    running,
  output logic [1:0]              fault_code
);

  localparam int SYNC_W = $clog2(SYNC_LEN);
  localparam int WDOG_W = $clog2(WDOG_CYC);

  dab_state_t state, state_nxt;
  dab_fault_t fault_q;

  logic signed [TAU_W-1:0] shadow_t1, shadow_t2, shadow_phi;
  logic signed [FS_W-1:0]  shadow_fs;
  logic                    shadow_full;
  logic                    has_cfg;
  logic signed [TAU_W-1:0] tgt_t1, tgt_t2, tgt_phi;
  logic [SYNC_W-1:0]       sync_cnt;
  logic [WDOG_W-1:0]       wdog_cnt;

  logic                    accept, legal, in_ramp;
  logic                    load_tgt, ramp_en, phi_en, wdog_expire;
  logic signed [TAU_W-1:0] rtgt_t1, rtgt_t2, rtgt_phi;
  logic signed [TAU_W-1:0] t1_nxt, t2_nxt, phi_nxt;

  assign cmd_ready  = !shadow_full && (state != ST_FAULT);
  assign accept     = cmd_valid && cmd_ready;
  assign legal      = cmd_legal(cmd_t1, cmd_t2, cmd_phi, cmd_fs);
  assign in_ramp    = (state == ST_RUN) || (state == ST_STOPPING);
  assign sync       = (state == ST_START);
  assign running    = (state == ST_START) || in_ramp;
  assign fault_code = fault_q;

  // Transfer, ramp and watchdog qualifiers; a shadow applied at a boundary is ramped toward on that same boundary.
  always_comb begin
    load_tgt    = shadow_full && !trip &&
                  ((state == ST_IDLE) || ((state == ST_RUN) && period_start));
    ramp_en     = period_start && !trip && in_ramp;
    phi_en      = ramp_en && (state == ST_RUN);
    wdog_expire = in_ramp && !period_start && (wdog_cnt == '0);
    rtgt_t1     = load_tgt ? shadow_t1  : tgt_t1;
    rtgt_t2     = load_tgt ? shadow_t2  : tgt_t2;
    rtgt_phi    = load_tgt ? shadow_phi : tgt_phi;
    if (state == ST_STOPPING) begin
      rtgt_t1 = '0;
      rtgt_t2 = '0;
    end
  end

  dab_ramp_step u_ramp_t1 (
    .cur  (t1),
    .tgt  (rtgt_t1),
    .step (TAU_STEP),
    .en   (ramp_en),
    .next (t1_nxt)
  );

  dab_ramp_step u_ramp_t2 (
    .cur  (t2),
    .tgt  (rtgt_t2),
    .step (TAU_STEP),
    .en   (ramp_en),
    .next (t2_nxt)
  );

  dab_ramp_step u_ramp_phi (
    .cur  (phi),
    .tgt  (rtgt_phi),
    .step (PHI_STEP),
    .en   (phi_en),
    .next (phi_nxt)
  );

  // Next-state decode; trip overrides everything else.
  always_comb begin
    state_nxt = state;
    if (trip) begin
      state_nxt = ST_FAULT;
    end else begin
      case (state)
        ST_IDLE:     if (enable && has_cfg) state_nxt = ST_START;
        ST_START:    if (sync_cnt == '0) state_nxt = ST_RUN;
        ST_RUN: begin
          if (wdog_expire)  state_nxt = ST_FAULT;
          else if (!enable) state_nxt = ST_STOPPING;
        end
        ST_STOPPING: begin
          if (wdog_expire)     state_nxt = ST_FAULT;
          else if (enable)     state_nxt = ST_RUN;
          else if (period_start && (t1_nxt == '0) && (t2_nxt == '0))
                               state_nxt = ST_IDLE;
        end
        ST_FAULT:    if (fault_clr) state_nxt = ST_IDLE;
        default:     state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register, sync-width and watchdog down-counters, fault code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      sync_cnt <= '0;
      wdog_cnt <= '0;
      fault_q  <= FC_NONE;
    end else begin
      state <= state_nxt;
      if (state == ST_START) begin
        if (sync_cnt != '0) sync_cnt <= sync_cnt - 1'b1;
      end else begin
        sync_cnt <= SYNC_W'(SYNC_LEN - 1);
      end
      if (!in_ramp || period_start)
        wdog_cnt <= WDOG_W'(WDOG_CYC - 1);
      else if (wdog_cnt != '0)
        wdog_cnt <= wdog_cnt - 1'b1;
      if (trip)
        fault_q <= FC_TRIP;
      else if (wdog_expire)
        fault_q <= FC_WDOG;
      else if ((state == ST_FAULT) && fault_clr)
        fault_q <= FC_NONE;
    end
  end

  // Command handshake into the shadow; a command coinciding with trip is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_t1   <= '0;
      shadow_t2   <= '0;
      shadow_phi  <= '0;
      shadow_fs   <= FS_DEFAULT;
      shadow_full <= 1'b0;
      has_cfg     <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      cmd_err <= 1'b0;
      if (accept && !trip) begin
        if (legal) begin
          shadow_t1   <= cmd_t1;
          shadow_t2   <= cmd_t2;
          shadow_phi  <= cmd_phi;
          shadow_fs   <= cmd_fs;
          shadow_full <= 1'b1;
          has_cfg     <= 1'b1;
        end else begin
          cmd_err <= 1'b1;
        end
      end else if (load_tgt || ((state == ST_FAULT) && (state_nxt == ST_IDLE))) begin
        shadow_full <= 1'b0;
      end
    end
  end

  // Targets, fs and slew-limited outputs; forced to 0 whenever heading into IDLE or FAULT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_t1  <= '0;
      tgt_t2  <= '0;
      tgt_phi <= '0;
      fs_DAB  <= FS_DEFAULT;
      t1      <= '0;
      t2      <= '0;
      phi     <= '0;
    end else begin
      if (load_tgt) begin
        tgt_t1  <= shadow_t1;
        tgt_t2  <= shadow_t2;
        tgt_phi <= shadow_phi;
        fs_DAB  <= shadow_fs;
      end
      if ((state_nxt == ST_IDLE) || (state_nxt == ST_FAULT)) begin
        t1  <= '0;
        t2  <= '0;
        phi <= '0;
      end else begin
        t1  <= t1_nxt;
        t2  <= t2_nxt;
        phi <= phi_nxt;
      end
    end
  end

endmodule

// File: tb/tb_dab_mod_sequencer.sv
// Directed bench for dab_mod_sequencer: command range table, then hand-written
// start/ramp, back-to-back command, soft stop, trip, watchdog and async reset sequences.
module tb_dab_mod_sequencer;

  localparam int WDOG = 200;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready, cmd_err;
  logic signed [8:0] cmd_t1, cmd_t2, cmd_phi;
  logic signed [18:0] cmd_fs;
  logic              enable, trip, fault_clr, period_start;
  logic signed [8:0] t1, t2, phi;
  logic signed [18:0] fs_DAB;
  logic              sync, running;
  logic [1:0]        fault_code;

  int nchk  = 0;
  int npass = 0;

  typedef struct {
    int t1;
    int t2;
    int phi;
    int fs;
    int err;
    int fs_after;
  } vec_t;

  vec_t vecs [12];

  always #5 clk = ~clk;

  dab_mod_sequencer #(.WDOG_CYC(WDOG)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_t1       (cmd_t1),
    .cmd_t2       (cmd_t2),
    .cmd_phi      (cmd_phi),
    .cmd_fs       (cmd_fs),
    .cmd_err      (cmd_err),
    .enable       (enable),
    .trip         (trip),
    .fault_clr    (fault_clr),
    .period_start (period_start),
    .t1           (t1),
    .t2           (t2),
    .phi          (phi),
    .fs_DAB       (fs_DAB),
    .sync         (sync),
    .running      (running),
    .fault_code   (fault_code)
  );

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ps();
    period_start = 1'b1;
    step();
    period_start = 1'b0;
  endtask

  task automatic set_cmd(input int a, input int b, input int p, input int f);
    cmd_t1  = 9'(a);
    cmd_t2  = 9'(b);
    cmd_phi = 9'(p);
    cmd_fs  = 19'(f);
  endtask

  // From IDLE with enable=1: expect a SYNC_LEN-wide sync, then RUN.
  task automatic start_run();
    int n;
    step();
    n = 0;
    while (sync && n < 10) begin
      n++;
      step();
    end
    chk("sync_width", n, 4);
    chk("run_entered", int'(running), 1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_t1"}, int'(t1), 0);
    chk({tag, "_t2"}, int'(t2), 0);
    chk({tag, "_phi"}, int'(phi), 0);
    chk({tag, "_fs"}, int'(fs_DAB), 50000);
    chk({tag, "_sync"}, int'(sync), 0);
    chk({tag, "_ready"}, int'(cmd_ready), 1);
    chk({tag, "_err"}, int'(cmd_err), 0);
    chk({tag, "_running"}, int'(running), 0);
    chk({tag, "_fault"}, int'(fault_code), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int e1, e2, ep, n;

    vecs[0]  = '{10, 20, -5, 60000, 0, 60000};
    vecs[1]  = '{10, 20, -256, 50000, 1, 60000};
    vecs[2]  = '{10, 20, 5, 200000, 1, 60000};
    vecs[3]  = '{0, 0, 0, 1000, 0, 1000};
    vecs[4]  = '{0, 0, 0, 999, 1, 1000};
    vecs[5]  = '{1, 2, 3, 150000, 0, 150000};
    vecs[6]  = '{1, 2, 3, 150001, 1, 150000};
    vecs[7]  = '{-1, 2, 3, 50000, 1, 150000};
    vecs[8]  = '{255, 255, 255, 50000, 0, 50000};
    vecs[9]  = '{5, 5, -255, 40000, 0, 40000};
    vecs[10] = '{5, -200, 0, 40000, 1, 40000};
    vecs[11] = '{100, 100, 40, 50000, 0, 50000};

    rst = 1'b1;
    cmd_valid = 1'b0;
    set_cmd(0, 0, 0, 0);
    enable = 1'b0;
    trip = 1'b0;
    fault_clr = 1'b0;
    period_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    step();

    // Command range table, applied in IDLE with enable low.
    for (int i = 0; i < 12; i++) begin
      set_cmd(vecs[i].t1, vecs[i].t2, vecs[i].phi, vecs[i].fs);
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      chk($sformatf("vec%0d_err", i), int'(cmd_err), vecs[i].err);
      chk($sformatf("vec%0d_ready_after", i), int'(cmd_ready), vecs[i].err);
      step();
      chk($sformatf("vec%0d_err_pulse", i), int'(cmd_err), 0);
      chk($sformatf("vec%0d_fs", i), int'(fs_DAB), vecs[i].fs_after);
      chk($sformatf("vec%0d_ready", i), int'(cmd_ready), 1);
      chk($sformatf("vec%0d_t1_idle", i), int'(t1), 0);
    end

    // Start and ramp toward t1=t2=100, phi=40.
    enable = 1'b1;
    start_run();
    e1 = 0;
    ep = 0;
    for (int k = 1; k <= 14; k++) begin
      step();
      pulse_ps();
      e1 = (e1 + 8 > 100) ? 100 : e1 + 8;
      ep = (ep + 4 > 40) ? 40 : ep + 4;
      chk($sformatf("ramp%0d_t1", k), int'(t1), e1);
      chk($sformatf("ramp%0d_t2", k), int'(t2), e1);
      chk($sformatf("ramp%0d_phi", k), int'(phi), ep);
    end

    // Back-to-back commands in RUN: second one waits for the first to be applied.
    set_cmd(120, 100, 40, 60000);
    cmd_valid = 1'b1;
    step();
    chk("b2b_ready_a", int'(cmd_ready), 0);
    set_cmd(90, 100, 40, 70000);
    step();
    chk("b2b_hold_ready", int'(cmd_ready), 0);
    chk("b2b_hold_fs", int'(fs_DAB), 50000);
    period_start = 1'b1;
    step();
    period_start = 1'b0;
    chk("b2b_a_fs", int'(fs_DAB), 60000);
    chk("b2b_a_t1", int'(t1), 108);
    chk("b2b_a_ready", int'(cmd_ready), 1);
    step();
    cmd_valid = 1'b0;
    chk("b2b_b_taken", int'(cmd_ready), 0);
    chk("b2b_b_fs_hold", int'(fs_DAB), 60000);
    step();
    pulse_ps();
    chk("b2b_b_fs", int'(fs_DAB), 70000);
    chk("b2b_b_t1", int'(t1), 100);

    // Command in the same cycle as period_start waits for the next boundary.
    set_cmd(100, 100, 40, 50000);
    cmd_valid = 1'b1;
    period_start = 1'b1;
    step();
    cmd_valid = 1'b0;
    period_start = 1'b0;
    chk("same_ps_t1", int'(t1), 92);
    chk("same_ps_fs", int'(fs_DAB), 70000);
    chk("same_ps_ready", int'(cmd_ready), 0);
    step();
    pulse_ps();
    chk("next_ps_t1", int'(t1), 100);
    chk("next_ps_fs", int'(fs_DAB), 50000);

    // Soft stop: 8 per boundary from 100, IDLE after the 13th.
    enable = 1'b0;
    step();
    chk("stop_running", int'(running), 1);
    e2 = 100;
    for (int k = 1; k <= 13; k++) begin
      step();
      pulse_ps();
      e2 = (e2 - 8 < 0) ? 0 : e2 - 8;
      chk($sformatf("stop%0d_t1", k), int'(t1), e2);
      chk($sformatf("stop%0d_t2", k), int'(t2), e2);
      chk($sformatf("stop%0d_phi", k), int'(phi), (k < 13) ? 40 : 0);
      chk($sformatf("stop%0d_running", k), int'(running), (k < 13) ? 1 : 0);
    end

    // Trip coinciding with period_start and a command.
    enable = 1'b1;
    start_run();
    repeat (3) begin
      step();
      pulse_ps();
    end
    chk("pretrip_t1", int'(t1), 24);
    chk("pretrip_phi", int'(phi), 12);
    set_cmd(50, 50, 10, 90000);
    cmd_valid = 1'b1;
    period_start = 1'b1;
    trip = 1'b1;
    step();
    cmd_valid = 1'b0;
    period_start = 1'b0;
    chk("trip_t1", int'(t1), 0);
    chk("trip_t2", int'(t2), 0);
    chk("trip_phi", int'(phi), 0);
    chk("trip_code", int'(fault_code), 1);
    chk("trip_running", int'(running), 0);
    chk("trip_sync", int'(sync), 0);
    chk("trip_ready", int'(cmd_ready), 0);
    chk("trip_err", int'(cmd_err), 0);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    chk("clr_with_trip_code", int'(fault_code), 1);
    chk("clr_with_trip_ready", int'(cmd_ready), 0);
    trip = 1'b0;
    step();
    chk("trip_released_code", int'(fault_code), 1);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    chk("clr_code", int'(fault_code), 0);
    chk("clr_ready", int'(cmd_ready), 1);
    chk("clr_running", int'(running), 0);
    chk("clr_fs", int'(fs_DAB), 50000);

    // Watchdog: no period_start in RUN.
    start_run();
    n = 0;
    while (fault_code != 2'd2 && n < WDOG + 20) begin
      step();
      n++;
    end
    chk("wdog_cycles", n, WDOG);
    chk("wdog_code", int'(fault_code), 2);
    chk("wdog_running", int'(running), 0);
    enable = 1'b0;
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    chk("wdog_clr_code", int'(fault_code), 0);

    // Asynchronous reset in the middle of a ramp.
    set_cmd(100, 100, 40, 80000);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    chk("prerst_fs", int'(fs_DAB), 80000);
    enable = 1'b1;
    start_run();
    repeat (2) begin
      step();
      pulse_ps();
    end
    chk("prerst_t1", int'(t1), 16);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    rst = 1'b0;
    repeat (3) step();
    chk("postrst_no_cfg", int'(running), 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
